// File: rtl/ppi_bus_master.sv
// Host-side initiator for the 8255 PPI: turns single-beat requests into timed cs/strobe bus cycles.
// An optional control-word write is issued after every reset, before any host traffic.
module ppi_bus_master #(
   parameter int          SETUP_CYC  = 1,
   parameter int          STROBE_CYC = 2,
   parameter int          HOLD_CYC   = 1,
   parameter int          INIT_EN    = 1,
   parameter logic [7:0]  INIT_CW    = 8'h80
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [1:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic       rsp_err,
   output logic [7:0] rsp_rdata,
   output logic       ppi_cs_n,
   output logic       ppi_read,
   output logic       ppi_write,
   output logic [1:0] ppi_a,
   output logic [7:0] ppi_d_out,
   output logic       ppi_d_oe,
   input  logic [7:0] ppi_d_in
);

   localparam logic [2:0] S_INIT   = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_SETUP  = 3'd2;
   localparam logic [2:0] S_STROBE = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

   logic [2:0] state;
   logic [3:0] cnt;
   logic       op_write;
   logic       op_int;     // init op: runs on the bus but never answers the host
   logic [7:0] cap;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_INIT;
         cnt       <= 4'd0;
         op_write  <= 1'b0;
         op_int    <= 1'b0;
         cap       <= 8'h00;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 8'h00;
         ppi_cs_n  <= 1'b1;
         ppi_read  <= 1'b0;
         ppi_write <= 1'b0;
         ppi_a     <= 2'b00;
         ppi_d_out <= 8'h00;
         ppi_d_oe  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            S_INIT: begin
               if (INIT_EN != 0) begin
                  op_write  <= 1'b1;
                  op_int    <= 1'b1;
                  state     <= S_SETUP;
                  cnt       <= SETUP_LD;
                  ppi_cs_n  <= 1'b0;
                  ppi_a     <= 2'b11;
                  ppi_d_out <= INIT_CW;
                  ppi_d_oe  <= 1'b1;
               end else begin
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
               end
            end
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  op_write  <= req_write;
                  op_int    <= 1'b0;
                  if (!req_write && req_addr == 2'b11) begin
                     // control register is write-only: answer with an error, no bus cycle
                     state     <= S_ERR;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 8'h00;
                  end else begin
                     state    <= S_SETUP;
                     cnt      <= SETUP_LD;
                     ppi_cs_n <= 1'b0;
                     ppi_a    <= req_addr;
                     ppi_d_oe <= req_write;
                     if (req_write) ppi_d_out <= req_wdata;
                  end
               end
            end
            S_SETUP: begin
               if (cnt == 4'd0) begin
                  state     <= S_STROBE;
                  cnt       <= STROBE_LD;
                  ppi_write <= op_write;
                  ppi_read  <= !op_write;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_STROBE: begin
               if (cnt == 4'd0) begin
                  state     <= S_HOLD;
                  cnt       <= HOLD_LD;
                  ppi_write <= 1'b0;
                  ppi_read  <= 1'b0;
                  if (!op_write) cap <= ppi_d_in;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_HOLD: begin
               if (cnt == 4'd0) begin
                  state     <= S_IDLE;
                  ppi_cs_n  <= 1'b1;
                  ppi_d_oe  <= 1'b0;
                  req_ready <= 1'b1;
                  if (!op_int) begin
                     rsp_valid <= 1'b1;
                     if (!op_write) rsp_rdata <= cap;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_ERR: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= S_INIT;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Scoreboard bench for ppi_bus_master: default instance plus a re-timed instance without init.
module tb_ppi_bus_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       sel = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [1:0] req_addr = 2'b00;
   logic [7:0] req_wdata = 8'h00;
   logic [7:0] d_in;

   logic       r1_ready, r1_rv, r1_err, r1_cs_n, r1_rd, r1_wr, r1_doe;
   logic [7:0] r1_rdata, r1_dout;
   logic [1:0] r1_a;
   logic       r2_ready, r2_rv, r2_err, r2_cs_n, r2_rd, r2_wr, r2_doe;
   logic [7:0] r2_rdata, r2_dout;
   logic [1:0] r2_a;

   ppi_bus_master dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(r1_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(r1_rv), .rsp_err(r1_err), .rsp_rdata(r1_rdata),
      .ppi_cs_n(r1_cs_n), .ppi_read(r1_rd), .ppi_write(r1_wr), .ppi_a(r1_a),
      .ppi_d_out(r1_dout), .ppi_d_oe(r1_doe), .ppi_d_in(d_in));

   ppi_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .INIT_EN(0)) dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(r2_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(r2_rv), .rsp_err(r2_err), .rsp_rdata(r2_rdata),
      .ppi_cs_n(r2_cs_n), .ppi_read(r2_rd), .ppi_write(r2_wr), .ppi_a(r2_a),
      .ppi_d_out(r2_dout), .ppi_d_oe(r2_doe), .ppi_d_in(d_in));

   wire       m_ready = sel ? r2_ready : r1_ready;
   wire       m_rv    = sel ? r2_rv    : r1_rv;
   wire       m_err   = sel ? r2_err   : r1_err;
   wire [7:0] m_rdata = sel ? r2_rdata : r1_rdata;
   wire       m_cs_n  = sel ? r2_cs_n  : r1_cs_n;
   wire       m_rd    = sel ? r2_rd    : r1_rd;
   wire       m_wr    = sel ? r2_wr    : r1_wr;
   wire [1:0] m_a     = sel ? r2_a     : r1_a;
   wire [7:0] m_dout  = sel ? r2_dout  : r1_dout;
   wire       m_doe   = sel ? r2_doe   : r1_doe;

   function automatic logic [7:0] model(input logic [1:0] a);
      case (a)
         2'b00:   model = 8'hF0;
         2'b01:   model = 8'h0F;
         2'b10:   model = 8'hFF;
         default: model = 8'h00;
      endcase
   endfunction

   // PPI only drives D while the read strobe is high, so late capture reads 00
   always_comb d_in = m_rd ? model(m_a) : 8'h00;

   typedef struct {
      logic       err;
      logic       chk;
      logic [7:0] rdata;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   int lat, cs_low, wr_n, rd_n, doe_n, both_n, bus_ok, gap;
   logic seen, got_err, ready_at_rsp;
   logic [7:0] got_rdata;

   // Issue one request (caller is at a negedge) and observe the bus until the response pulse.
   task automatic run_op(input logic w, input logic [1:0] a, input logic [7:0] wd);
      exp_t e;
      req_write = w; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      gap = 0; lat = 0; cs_low = 0; wr_n = 0; rd_n = 0; doe_n = 0; both_n = 0; bus_ok = 0;
      seen = 1'b0; got_err = 1'b0; got_rdata = 8'h00; ready_at_rsp = 1'b0;
      while (!m_ready && gap < 20) begin
         @(negedge clk);
         gap++;
      end
      if (!m_ready) begin
         tests++; fails++;
         $display("FAIL ready_timeout: req_ready=%0b after %0d cycles, required 1", m_ready, gap);
         req_valid = 1'b0;
         return;
      end
      e.err = !w && a == 2'b11;
      e.chk = !w;
      e.rdata = e.err ? 8'h00 : model(a);
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (!m_cs_n) begin
            cs_low++;
            if (m_a == a && m_doe == w && (!w || m_dout == wd)) bus_ok++;
         end
         if (m_wr) wr_n++;
         if (m_rd) rd_n++;
         if (m_doe) doe_n++;
         if (m_wr && m_rd) both_n++;
         if (m_rv) begin
            seen = 1'b1; got_err = m_err; got_rdata = m_rdata; ready_at_rsp = m_ready;
         end
      end
      if (!seen) begin
         tests++; fails++;
         $display("FAIL rsp_timeout: no rsp_valid within %0d cycles of accept", lat);
         void'(sb.pop_back());
      end
   endtask

   task automatic test_reset();
      logic [5:0] cs_m, wr_m, rdy_m;
      int ok, rv_n;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if ({m_ready, m_rv, m_err, m_rdata, m_cs_n, m_rd, m_wr, m_a, m_dout, m_doe} !==
          {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0}) begin
         fails++;
         $display("FAIL reset_values: ready=%0b rv=%0b err=%0b rdata=%h cs_n=%0b rd=%0b wr=%0b a=%0d dout=%h doe=%0b",
                  m_ready, m_rv, m_err, m_rdata, m_cs_n, m_rd, m_wr, m_a, m_dout, m_doe);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      cs_m = '0; wr_m = '0; rdy_m = '0; ok = 0; rv_n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         cs_m[c] = !m_cs_n; wr_m[c] = m_wr; rdy_m[c] = m_ready;
         if (!m_cs_n && m_a == 2'b11 && m_doe && m_dout == 8'h80) ok++;
         if (m_rv) rv_n++;
      end
      tests++;
      if (cs_m !== 6'b011110) begin fails++; $display("FAIL init_cs: got %b required 011110", cs_m); end
      tests++;
      if (wr_m !== 6'b001100) begin fails++; $display("FAIL init_write: got %b required 001100", wr_m); end
      tests++;
      if (rdy_m !== 6'b100000) begin fails++; $display("FAIL init_ready: got %b required 100000", rdy_m); end
      tests++;
      if (ok !== 4) begin fails++; $display("FAIL init_bus: got %0d good cycles required 4", ok); end
      tests++;
      if (rv_n !== 0) begin fails++; $display("FAIL init_rsp: got %0d rsp_valid required 0", rv_n); end
   endtask

   task automatic test_writes();
      exp_t e;
      logic [1:0] addrs [3];
      addrs[0] = 2'b00; addrs[1] = 2'b01; addrs[2] = 2'b10;
      for (int i = 0; i < 3; i++) begin
         run_op(1'b1, addrs[i], 8'h80);
         tests++;
         if (lat !== 5 || cs_low !== 4 || wr_n !== 2 || rd_n !== 0 || bus_ok !== 4) begin
            fails++;
            $display("FAIL write%0d_timing: lat=%0d cs=%0d wr=%0d rd=%0d ok=%0d required 5/4/2/0/4",
                     i, lat, cs_low, wr_n, rd_n, bus_ok);
         end
         tests++;
         if (ready_at_rsp !== 1'b1 || (i > 0 && gap !== 0)) begin
            fails++;
            $display("FAIL write%0d_b2b: ready_at_rsp=%0b gap=%0d required 1/0", i, ready_at_rsp, gap);
         end
         if (seen) begin
            e = sb.pop_front();
            tests++;
            if (got_err !== e.err) begin
               fails++;
               $display("FAIL write%0d_err: got %0b required %0b", i, got_err, e.err);
            end
         end
      end
      @(negedge clk);
      tests++;
      if (m_rv !== 1'b0) begin fails++; $display("FAIL rsp_pulse_width: rsp_valid=%0b required 0", m_rv); end
   endtask

   task automatic test_reads();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         run_op(1'b0, 2'(i), 8'h00);
         tests++;
         if (lat !== 5 || cs_low !== 4 || rd_n !== 2 || wr_n !== 0 || doe_n !== 0 || both_n !== 0) begin
            fails++;
            $display("FAIL read%0d_timing: lat=%0d cs=%0d rd=%0d wr=%0d doe=%0d both=%0d required 5/4/2/0/0/0",
                     i, lat, cs_low, rd_n, wr_n, doe_n, both_n);
         end
         if (seen) begin
            e = sb.pop_front();
            tests++;
            if (got_err !== e.err || got_rdata !== e.rdata) begin
               fails++;
               $display("FAIL read%0d_data: got err=%0b rdata=%h required err=%0b rdata=%h",
                        i, got_err, got_rdata, e.err, e.rdata);
            end
         end
      end
   endtask

   task automatic test_illegal();
      exp_t e;
      run_op(1'b0, 2'b11, 8'h00);
      tests++;
      if (lat !== 1 || cs_low !== 0 || rd_n !== 0 || wr_n !== 0) begin
         fails++;
         $display("FAIL illegal_bus: lat=%0d cs=%0d rd=%0d wr=%0d required 1/0/0/0", lat, cs_low, rd_n, wr_n);
      end
      if (seen) begin
         e = sb.pop_front();
         tests++;
         if (got_err !== e.err || got_rdata !== e.rdata) begin
            fails++;
            $display("FAIL illegal_rsp: got err=%0b rdata=%h required err=%0b rdata=%h",
                     got_err, got_rdata, e.err, e.rdata);
         end
      end
      @(negedge clk);
      tests++;
      if (m_ready !== 1'b1 || m_rv !== 1'b0) begin
         fails++;
         $display("FAIL illegal_after: ready=%0b rv=%0b required 1/0", m_ready, m_rv);
      end
   endtask

   task automatic test_reset_mid();
      int cs_n, wr_c, ok, rv_n;
      req_write = 1'b1; req_addr = 2'b01; req_wdata = 8'h55; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (m_wr !== 1'b1) begin fails++; $display("FAIL mid_strobe: write=%0b required 1", m_wr); end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      tests++;
      if ({m_wr, m_cs_n, m_doe, m_rv} !== 4'b0100) begin
         fails++;
         $display("FAIL mid_reset: wr=%0b cs_n=%0b doe=%0b rv=%0b required 0/1/0/0", m_wr, m_cs_n, m_doe, m_rv);
      end
      cs_n = 0; wr_c = 0; ok = 0; rv_n = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (!m_cs_n) cs_n++;
         if (m_wr) wr_c++;
         if (!m_cs_n && m_a == 2'b11 && m_doe && m_dout == 8'h80) ok++;
         if (m_rv) rv_n++;
      end
      tests++;
      if (cs_n !== 4 || wr_c !== 2 || ok !== 4 || rv_n !== 0) begin
         fails++;
         $display("FAIL mid_reinit: cs=%0d wr=%0d ok=%0d rv=%0d required 4/2/4/0", cs_n, wr_c, ok, rv_n);
      end
   endtask

   task automatic test_sweep();
      exp_t e;
      sel = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      tests++;
      if (m_ready !== 1'b0) begin fails++; $display("FAIL sweep_ready_c1: got %0b required 0", m_ready); end
      @(negedge clk);
      tests++;
      if (m_ready !== 1'b1) begin fails++; $display("FAIL sweep_ready_c2: got %0b required 1", m_ready); end
      run_op(1'b1, 2'b10, 8'h3C);
      tests++;
      if (lat !== 7 || cs_low !== 6 || wr_n !== 1 || bus_ok !== 6) begin
         fails++;
         $display("FAIL sweep_write: lat=%0d cs=%0d wr=%0d ok=%0d required 7/6/1/6", lat, cs_low, wr_n, bus_ok);
      end
      if (seen) begin
         e = sb.pop_front();
         tests++;
         if (got_err !== e.err) begin fails++; $display("FAIL sweep_write_err: got %0b required %0b", got_err, e.err); end
      end
      run_op(1'b0, 2'b01, 8'h00);
      tests++;
      if (lat !== 7 || cs_low !== 6 || rd_n !== 1 || doe_n !== 0) begin
         fails++;
         $display("FAIL sweep_read: lat=%0d cs=%0d rd=%0d doe=%0d required 7/6/1/0", lat, cs_low, rd_n, doe_n);
      end
      if (seen) begin
         e = sb.pop_front();
         tests++;
         if (got_err !== e.err || got_rdata !== e.rdata) begin
            fails++;
            $display("FAIL sweep_read_data: got err=%0b rdata=%h required err=%0b rdata=%h",
                     got_err, got_rdata, e.err, e.rdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_writes();
      test_reads();
      test_illegal();
      test_reset_mid();
      test_sweep();
      tests++;
      if (sb.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: %0d left required 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ppi_bus_master.md
Name: ppi_bus_master

Overview:
- CPU-side initiator for the ppi_8255 peripheral. It turns single-beat host requests (read/write, 2-bit address, 8-bit data) into timed 8255 bus cycles on cs/read/write/A/D.
- After reset it writes a programmable control word to A=11, so the PPI is configured before any host traffic.
- Sits between a host or sequencer and the ppi_8255 D/A/cs/read/write pins. The top level owns the tri-state D bus through d_oe.

Parameters:
- SETUP_CYC, 1, cycles cs_n/A/D are valid before the strobe asserts (range 1..15)
- STROBE_CYC, 2, cycles read or write is held high (range 1..15)
- HOLD_CYC, 1, cycles cs_n/A/D are held after the strobe drops (range 1..15)
- INIT_EN, 1, 1 = issue the control-word write automatically after reset
- INIT_CW, 8'h80, control word written to A=11 at init

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  host request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  2  PPI register address (00=PA, 01=PB, 10=PC, 11=control)
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse for each host request
- rsp_err  out  1  qualifies rsp_valid; 1 = illegal request
- rsp_rdata  out  8  read data, valid while rsp_valid=1
- ppi_cs_n  out  1  chip select, active low
- ppi_read  out  1  read strobe, active high
- ppi_write  out  1  write strobe, active high
- ppi_a  out  2  address to the PPI
- ppi_d_out  out  8  data driven onto D
- ppi_d_oe  out  1  1 = top level drives D with ppi_d_out
- ppi_d_in  in  8  D bus as seen by the master

Behaviour:
- All outputs registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, ppi_cs_n=1, ppi_read=0, ppi_write=0, ppi_a=0, ppi_d_out=0, ppi_d_oe=0.
- FSM states: INIT, IDLE, SETUP, STROBE, HOLD, ERR. Reset enters INIT.
- INIT, INIT_EN=1: load the op as write, A=11, data=INIT_CW. Go to SETUP. Flag the op internal, so it produces no rsp_valid.
- INIT, INIT_EN=0: go to IDLE.
- IDLE: req_ready=1. Handshake completes when req_valid && req_ready; latch req_write/req_addr/req_wdata; req_ready drops the next cycle.
- Accepted read with req_addr=11 (control register is not readable): go to ERR, no bus cycle. ERR lasts 1 cycle with rsp_valid=1, rsp_err=1, rsp_rdata=0. Then IDLE.
- Any other accepted request: go to SETUP.
- SETUP, SETUP_CYC cycles: ppi_cs_n=0, ppi_a=latched address, strobes low. Writes: ppi_d_oe=1, ppi_d_out=wdata. Reads: ppi_d_oe=0.
- STROBE, STROBE_CYC cycles: as SETUP, plus ppi_write=1 (write) or ppi_read=1 (read).
  - Read data: capture ppi_d_in on the clock edge ending the last STROBE cycle.
  - Write and read strobes are never high together.
- HOLD, HOLD_CYC cycles: strobes low. cs_n, A, d_out and d_oe held as in SETUP.
- Leaving HOLD:
  - Return to IDLE with ppi_cs_n=1, ppi_d_oe=0; ppi_a and ppi_d_out keep their last values.
  - Host op: rsp_valid=1 for exactly the first IDLE cycle. rsp_err=0. rsp_rdata=captured data for reads, unchanged for writes.
  - req_ready=1 in that same cycle, so back-to-back requests are allowed.
- Timing: a single down-counter (4 bits) counts phase length; it reloads on every state entry.
  - Host bus op latency: accept edge to rsp_valid = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles (5 at defaults).
  - ppi_cs_n low for SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.
- Host signals are ignored while req_ready=0. A request held across that window is accepted on the first req_ready=1 cycle.
- Reset mid-operation:
  - On the reset edge all outputs return to reset values: strobes drop immediately, no rsp_valid.
  - After reset deasserts, INIT runs again.
  - A pending host request is lost and must be re-issued.

Test Plan:
- Init sequence: reset high 2 cycles then low; defaults.
  - Cycle 1: INIT.
  - Cycles 2-5: cs_n=0, A=11, d_oe=1, d_out=80.
  - ppi_write=1 in cycles 3-4 only.
  - Cycle 6: cs_n=1, req_ready=1, rsp_valid stays 0.
- Port writes: after init, write 80 to A=00, then 01, then 10, each back-to-back.
  - Each shows cs_n low 4 cycles and write high 2 cycles.
  - rsp_valid pulses 5 cycles after each accept; the next request is accepted in the same cycle.
- Port reads: PPI model drives D=F0 (A=00), 0F (A=01), FF (A=10).
  - Reads of 00/01/10 return rsp_rdata=F0, 0F, FF with rsp_err=0.
  - d_oe=0 throughout; ppi_read high 2 cycles.
- Illegal read: read A=11.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=00.
  - cs_n stays 1, no strobe.
- Reset mid-cycle: assert reset during the 1st STROBE cycle of a write.
  - Next cycle: write=0, cs_n=1, d_oe=0.
  - No rsp_valid; init write of 80 to A=11 repeats after release.
- Parameter sweep: SETUP=3, STROBE=1, HOLD=2, INIT_EN=0.
  - req_ready=1 one cycle after reset.
  - Write: cs_n low 6 cycles, write high 1 cycle.
  - rsp_valid 7 cycles after accept.
